// File: rtl/param_frame_readback_tx.sv
`default_nettype none
// ============================================================================
// Module   : param_frame_readback_tx
// Function : Reads FRAME_LEN bytes of parameter RAM from address 0 upward and
//            transmits each as UART 8N1, LSB first, on its own serial line.
//            Define READBACK_CSUM_EN to append an XOR checksum byte.
// Revision : 1.0  initial release
// ============================================================================
module param_frame_readback_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_LEN    = 73,
    parameter int ADDR_W       = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5,
        S_CSUM  = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    localparam logic [15:0]       c_bit_last = 16'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] c_idx_one  = ADDR_W'(1);

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic                rd_q,       rd_d;
    logic                tx_q,       tx_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [15:0]         cnt_q,      cnt_d;
    logic [2:0]          bit_q,      bit_d;
    logic [7:0]          shift_q,    shift_d;
`ifdef READBACK_CSUM_EN
    logic [7:0]          acc_q,      acc_d;
    logic                csum_q,     csum_d;
`endif

    logic w_bit_end;
    logic w_last_byte;

    assign w_bit_end   = (cnt_q == c_bit_last);
    assign w_last_byte = (byte_idx_q == c_last_idx);

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        rd_d       = 1'b0;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
`ifdef READBACK_CSUM_EN
        acc_d      = acc_q;
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (start) begin
                    state_d    = S_FETCH;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    addr_d     = '0;
                    rd_d       = 1'b1;
`ifdef READBACK_CSUM_EN
                    acc_d      = '0;
                    csum_d     = 1'b0;
`endif
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                // RAM data is only trusted on this cycle, one after the read strobe.
`ifdef READBACK_CSUM_EN
                if (csum_q) begin
                    shift_d = acc_q;
                end else begin
                    shift_d = ram_data;
                    acc_d   = acc_q ^ ram_data;
                end
`else
                shift_d = ram_data;
`endif
                tx_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    cnt_d = '0;
`ifdef READBACK_CSUM_EN
                    if (csum_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end else if (!w_last_byte) begin
                        byte_idx_d = byte_idx_q + c_idx_one;
                        addr_d     = byte_idx_q + c_idx_one;
                        rd_d       = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        csum_d  = 1'b1;
                        state_d = S_CSUM;
                    end
`else
                    if (!w_last_byte) begin
                        byte_idx_d = byte_idx_q + c_idx_one;
                        addr_d     = byte_idx_q + c_idx_one;
                        rd_d       = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FIN;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            // Stands in for FETCH so the checksum byte keeps the 2-cycle gap.
            S_CSUM:  state_d = S_LATCH;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
`ifdef READBACK_CSUM_EN
            acc_q      <= '0;
            csum_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
`ifdef READBACK_CSUM_EN
            acc_q      <= acc_d;
            csum_q     <= csum_d;
`endif
        end
    end

    assign ram_rd   = rd_q;
    assign ram_addr = addr_q;
    assign tx_out   = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_param_frame_readback_tx.sv
`default_nettype none
// Bench for param_frame_readback_tx: per-cycle line log, UART decoder and a
// byte-level frame model built from RAM contents.
module tb_param_frame_readback_tx;

    localparam int C  = 4;
    localparam int FL = 3;
`ifdef READBACK_CSUM_EN
    localparam int NB = FL + 1;
`else
    localparam int NB = FL;
`endif
    localparam int L    = NB * (10 * C + 2);
    localparam int LOGN = 8192;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic       ram_rd;
    logic [7:0] ram_addr;
    logic [7:0] ram_data = 8'h00;
    logic       tx_out;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [7:0] mem [256];
    logic       tx_log   [LOGN];
    logic       rd_log   [LOGN];
    logic       done_log [LOGN];
    logic       busy_log [LOGN];
    logic [7:0] addr_log [LOGN];

    logic [8:0] dec_b [$];
    int         dec_s [$];
    logic [8:0] exp_b [$];

    param_frame_readback_tx #(
        .CLKS_PER_BIT(C),
        .FRAME_LEN   (FL),
        .ADDR_W      (8)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (start),
        .ram_rd  (ram_rd),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .tx_out  (tx_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous-read RAM; outside the read cycle the bus carries noise.
    always @(posedge CLK) begin
        if (ram_rd) ram_data <= mem[ram_addr];
        else        ram_data <= 8'($urandom);
    end

    always @(negedge CLK) begin
        if (cyc < LOGN) begin
            tx_log[cyc]   = tx_out;
            rd_log[cyc]   = ram_rd;
            done_log[cyc] = done;
            busy_log[cyc] = busy;
            addr_log[cyc] = ram_addr;
        end
    end

    task automatic load_default();
        mem[0] = 8'h55; mem[1] = 8'hA3; mem[2] = 8'h01;
    endtask

    // Expected line content: FRAME_LEN bytes from RAM, optionally followed by their XOR.
    task automatic build_expected(input int frames);
        logic [7:0] x;
        exp_b.delete();
        for (int f = 0; f < frames; f++) begin
            x = 8'h00;
            for (int k = 0; k < FL; k++) begin
                exp_b.push_back({1'b1, mem[k]});
                x = x ^ mem[k];
            end
`ifdef READBACK_CSUM_EN
            exp_b.push_back({1'b1, x});
`endif
        end
    endtask

    // Decode 8N1 characters from the logged line; bit 8 of each entry is the stop bit.
    task automatic decode(input int from, input int to);
        int c;
        logic [8:0] v;
        dec_b.delete();
        dec_s.delete();
        c = (from < 1) ? 1 : from;
        while (c < to && c + 10 * C < LOGN) begin
            if (tx_log[c] == 1'b0 && tx_log[c-1] == 1'b1) begin
                for (int i = 0; i < 9; i++) v[i] = tx_log[c + C * (i + 1) + C / 2];
                dec_b.push_back(v);
                dec_s.push_back(c);
                c = c + 10 * C;
            end else begin
                c = c + 1;
            end
        end
    endtask

    task automatic pulse_start(output int e0);
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 e0 = cyc; start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_bytes(input string name);
        tests++;
        if (dec_b.size() !== exp_b.size()) begin
            fails++;
            $display("FAIL %s byte count: got %0d want %0d", name, dec_b.size(), exp_b.size());
        end else begin
            foreach (exp_b[i]) begin
                tests++;
                if (dec_b[i] !== exp_b[i]) begin
                    fails++;
                    $display("FAIL %s byte %0d: got %h want %h", name, i, dec_b[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0;
        repeat (3) @(posedge CLK);
        #1 start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        tests += 5;
        if (tx_out !== 1'b1)   begin fails++; $display("FAIL reset tx_out: got %b want 1", tx_out); end
        if (ram_rd !== 1'b0)   begin fails++; $display("FAIL reset ram_rd: got %b want 0", ram_rd); end
        if (ram_addr !== 8'h0) begin fails++; $display("FAIL reset ram_addr: got %h want 00", ram_addr); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
        if (done !== 1'b0)     begin fails++; $display("FAIL reset done: got %b want 0", done); end
        @(posedge CLK); #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        tests++;
        if (busy !== 1'b0 || ram_rd !== 1'b0) begin
            fails++; $display("FAIL start_during_reset: busy=%b ram_rd=%b want 0,0", busy, ram_rd);
        end
    endtask

    task automatic test_frame();
        int e0, at, nrd, k;
        load_default();
        pulse_start(e0);
        wait_done(L + 200, at);
        tests++;
        if (at < 0) begin
            fails++; $display("FAIL frame done timeout: got none want at %0d", e0 + L);
            return;
        end
        tests += 4;
        if (at !== e0 + L) begin fails++; $display("FAIL frame done latency: got %0d want %0d", at - e0, L); end
        if (tx_log[e0+1] !== 1'b1 || tx_log[e0+2] !== 1'b0) begin
            fails++; $display("FAIL frame first fall: got %b%b want 10", tx_log[e0+1], tx_log[e0+2]);
        end
        if (busy_log[e0] !== 1'b1 || busy_log[at-1] !== 1'b1) begin
            fails++; $display("FAIL frame busy during: got %b/%b want 1/1", busy_log[e0], busy_log[at-1]);
        end
        if (busy_log[at] !== 1'b0) begin fails++; $display("FAIL frame busy at done: got %b want 0", busy_log[at]); end
        nrd = 0;
        for (int c = e0; c <= at; c++) begin
            if (rd_log[c] === 1'b1) begin
                k = nrd;
                nrd++;
                tests++;
                if (addr_log[c] !== 8'(k)) begin
                    fails++; $display("FAIL frame ram_addr #%0d: got %0d want %0d", k, addr_log[c], k);
                end
            end
        end
        tests++;
        if (nrd !== FL) begin fails++; $display("FAIL frame ram_rd count: got %0d want %0d", nrd, FL); end
        decode(e0, at);
        build_expected(1);
        check_bytes("frame");
        repeat (3) @(negedge CLK);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL frame idle after: busy=%b done=%b want 0,0", busy, done);
        end
    endtask

    task automatic test_bit_timing();
        int e0, at, s;
        logic [9:0] pat;
        logic lvl;
        bit bad;
        load_default();
        pattern_init: pat = {1'b1, 8'h55, 1'b0};
        pulse_start(e0);
        wait_done(L + 200, at);
        s = e0 + 2;
        for (int b = 0; b < 10; b++) begin
            lvl = pat[b];
            bad = 1'b0;
            for (int j = 0; j < C; j++) if (tx_log[s + b*C + j] !== lvl) bad = 1'b1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL bit_timing bit %0d: got %b%b%b%b want %0d x%0d", b,
                         tx_log[s+b*C], tx_log[s+b*C+1], tx_log[s+b*C+2], tx_log[s+b*C+3], lvl, C);
            end
        end
        bad = 1'b0;
        for (int j = 10*C; j < 10*C + 2; j++) if (tx_log[s + j] !== 1'b1) bad = 1'b1;
        tests += 2;
        if (bad) begin fails++; $display("FAIL gap high: got low inside gap want 1"); end
        if (tx_log[s + 10*C + 2] !== 1'b0) begin
            fails++; $display("FAIL gap length: next start got %b want 0", tx_log[s + 10*C + 2]);
        end
    endtask

    task automatic test_random_frames();
        int e0, at;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < FL; k++) mem[k] = 8'($urandom);
            repeat ($urandom_range(0, 7)) @(posedge CLK);
            pulse_start(e0);
            wait_done(L + 200, at);
            tests++;
            if (at !== e0 + L) begin
                fails++; $display("FAIL random %0d done: got %0d want %0d", it, at, e0 + L);
            end
            decode(e0, e0 + L);
            build_expected(1);
            check_bytes("random");
        end
        load_default();
    endtask

    task automatic test_ignore_start();
        int e0, ndone, fin;
        load_default();
        pulse_start(e0);
        for (int k = 0; k < L + 100; k++) begin
            @(posedge CLK); #1;
            start = ((cyc - e0) == 9) || ((cyc - e0) == 59);
        end
        start = 1'b0;
        @(negedge CLK);
        fin = e0 + L + 100;
        ndone = 0;
        for (int c = e0; c < fin; c++) if (done_log[c] === 1'b1) ndone++;
        tests += 3;
        if (ndone !== 1) begin fails++; $display("FAIL ignore done count: got %0d want 1", ndone); end
        if (done_log[e0 + L] !== 1'b1) begin fails++; $display("FAIL ignore done time: got %b want 1", done_log[e0+L]); end
        if (busy_log[e0 + L + 50] !== 1'b0) begin fails++; $display("FAIL ignore second frame: busy got %b want 0", busy_log[e0+L+50]); end
        decode(e0, fin);
        build_expected(1);
        check_bytes("ignore");
    endtask

    task automatic test_reset_midframe();
        int e0, at, r, ndone;
        load_default();
        pulse_start(e0);
        // Byte 1 data bit 3 occupies cycles e0+60..e0+63 (byte 0xA3: bit 3 is 0).
        while (cyc < e0 + 62) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0; r = cyc;
        @(negedge CLK);
        tests += 4;
        if (tx_log[r-1] !== 1'b0) begin fails++; $display("FAIL midreset pre tx: got %b want 0", tx_log[r-1]); end
        if (tx_out !== 1'b1) begin fails++; $display("FAIL midreset tx_out: got %b want 1", tx_out); end
        if (busy !== 1'b0) begin fails++; $display("FAIL midreset busy: got %b want 0", busy); end
        if (done !== 1'b0) begin fails++; $display("FAIL midreset done: got %b want 0", done); end
        repeat (200) @(negedge CLK);
        ndone = 0;
        for (int c = e0; c < r + 200; c++) if (done_log[c] === 1'b1) ndone++;
        tests++;
        if (ndone !== 0) begin fails++; $display("FAIL midreset done pulses: got %0d want 0", ndone); end
        pulse_start(e0);
        wait_done(L + 200, at);
        tests += 2;
        if (at !== e0 + L) begin fails++; $display("FAIL midreset restart done: got %0d want %0d", at, e0 + L); end
        if (rd_log[e0] !== 1'b1 || addr_log[e0] !== 8'h00) begin
            fails++; $display("FAIL midreset restart addr: rd=%b addr=%h want 1,00", rd_log[e0], addr_log[e0]);
        end
        decode(e0, e0 + L);
        build_expected(1);
        check_bytes("restart");
    endtask

    task automatic test_back_to_back();
        int e0, d[$], fin;
        load_default();
        @(posedge CLK); #1 start = 1'b1;
        @(posedge CLK); #1 e0 = cyc;
        while (cyc < e0 + 200) begin @(posedge CLK); #1; end
        start = 1'b0;
        fin = e0 + 2 * L + 150;
        while (cyc < fin) @(negedge CLK);
        for (int c = e0; c < fin; c++) if (done_log[c] === 1'b1) d.push_back(c);
        tests++;
        if (d.size() !== 2) begin
            fails++; $display("FAIL b2b done count: got %0d want 2", d.size());
            return;
        end
        tests += 3;
        if (d[0] !== e0 + L) begin fails++; $display("FAIL b2b first done: got %0d want %0d", d[0] - e0, L); end
        // Second start bit falls 3 cycles after the one-cycle done pulse has ended.
        if (tx_log[d[0] + 3] !== 1'b1 || tx_log[d[0] + 4] !== 1'b0) begin
            fails++; $display("FAIL b2b second start: got %b%b want 10", tx_log[d[0]+3], tx_log[d[0]+4]);
        end
        if (d[1] !== d[0] + 2 + L) begin fails++; $display("FAIL b2b second done: got %0d want %0d", d[1] - d[0], L + 2); end
        decode(e0, fin);
        build_expected(2);
        check_bytes("b2b");
    endtask

    initial begin
        RESET = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        load_default();
        test_reset();
        test_frame();
        test_bit_timing();
        test_random_frames();
        test_ignore_start();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
